// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU issue unit: instruction field layout,
// FSM state encoding and operand-load select values.
package alu_exec_pkg;

    // Instruction word layout: {op, td_idx, src1_idx, src2_idx}, 4 bits each
    localparam int OP_MSB = 15;
    localparam int TD_MSB = 11;
    localparam int S1_MSB = 7;
    localparam int S2_MSB = 3;
    localparam int FLD_W  = 4;

    // Operand load port RAM select
    localparam logic LD_SRC1 = 1'b0;
    localparam logic LD_SRC2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_exec_regfile.sv
// 2**AW x DW register file with async clear, one synchronous write port and
// one registered read port. A same-edge read and write returns the old word.
module alu_exec_regfile #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [2**AW-1:0][DW-1:0] mem_q;
    logic [DW-1:0]            rdata_q;

    // Storage: cleared on reset, written on strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  mem_q        <= '0;
        else if (we) mem_q[waddr] <= wdata;
    end

    // Registered read; holds its value while re is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata_q <= '0;
        else if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential issuer for an external combinational ALU. Accepts one
// instruction per handshake, fetches operands from two operand RAMs, captures
// the ALU result/PSW and writes the result into a readable result RAM.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [15:0]   op_code,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [3:0]    alu_opcode,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    output logic [3:0]    alu_src3,
    input  logic [DW-1:0] alu_td,
    input  logic [2:0]    alu_psw,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic [AW-1:0] done_idx,
    output logic [2:0]    psw_q,
    output logic          busy,
    output logic [CW-1:0] instr_cnt
);

    state_e        state_q;
    logic [15:0]   instr_q;
    logic [DW-1:0] res_q;
    logic [2:0]    psw_r_q;
    logic          ready_q, busy_q, done_q;
    logic [AW-1:0] done_idx_q;
    logic [CW-1:0] cnt_q;

    logic [AW-1:0] td_idx, s1_idx, s2_idx;
    assign td_idx = instr_q[TD_MSB -: AW];
    assign s1_idx = instr_q[S1_MSB -: AW];
    assign s2_idx = instr_q[S2_MSB -: AW];

    // Issue FSM and handshake; every output it drives is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            res_q      <= '0;
            psw_r_q    <= '0;
            psw_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (op_valid && ready_q) begin
                    instr_q <= op_code;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ISSUE;
                end
                // operand RAM reads are launched by re below
                ISSUE: state_q <= EXEC;
                EXEC: begin
                    res_q   <= alu_td;
                    psw_r_q <= alu_psw;
                    state_q <= WB;
                end
                WB: begin
                    psw_q      <= psw_r_q;
                    done_q     <= 1'b1;
                    done_idx_q <= td_idx;
                    cnt_q      <= cnt_q + CW'(1);
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand RAMs: loads accepted any cycle, read only in ISSUE so the
    // operand outputs stay stable through EXEC
    alu_exec_regfile #(.AW(AW), .DW(DW)) u_src1 (
        .clk(clk), .rst_n(rst_n),
        .we(ld_en && (ld_sel == LD_SRC1)), .waddr(ld_addr), .wdata(ld_data),
        .re(state_q == ISSUE), .raddr(s1_idx), .rdata(alu_src1)
    );

    alu_exec_regfile #(.AW(AW), .DW(DW)) u_src2 (
        .clk(clk), .rst_n(rst_n),
        .we(ld_en && (ld_sel == LD_SRC2)), .waddr(ld_addr), .wdata(ld_data),
        .re(state_q == ISSUE), .raddr(s2_idx), .rdata(alu_src2)
    );

    // Result RAM: written in WB, read every cycle
    alu_exec_regfile #(.AW(AW), .DW(DW)) u_td (
        .clk(clk), .rst_n(rst_n),
        .we(state_q == WB), .waddr(td_idx), .wdata(res_q),
        .re(1'b1), .raddr(rd_addr), .rdata(rd_data)
    );

    assign op_ready   = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_idx   = done_idx_q;
    assign instr_cnt  = cnt_q;
    assign alu_opcode = instr_q[OP_MSB -: FLD_W];
    assign alu_src3   = instr_q[S2_MSB -: FLD_W];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: stub adder ALU, directed scenarios plus random
// instructions checked against an array-based reference model.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    // Narrow counter so the wrap-around is reachable in a short run
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [15:0]   op_code = '0;
    logic          ld_en = 1'b0;
    logic          ld_sel = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_src1, alu_src2;
    logic [3:0]    alu_src3;
    logic [DW-1:0] alu_td;
    logic [2:0]    alu_psw;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          done;
    logic [AW-1:0] done_idx;
    logic [2:0]    psw_q;
    logic          busy;
    logic [CW-1:0] instr_cnt;

    int cmps = 0;
    int errs = 0;

    // Reference model state
    logic [15:0] s1m [16];
    logic [15:0] s2m [16];
    logic [15:0] tdm [16];
    logic [2:0]  pswm;
    int          cntm;

    always #5 clk = ~clk;

    // Adder ALU rule: {psw, td}, psw = {carry, zero, msb}
    function automatic logic [18:0] ref_alu(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[16], s[15:0] == 16'h0, s[15], s[15:0]};
    endfunction

    assign {alu_psw, alu_td} = ref_alu(alu_src1, alu_src2);

    alu_exec_unit #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_opcode(alu_opcode), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_src3(alu_src3), .alu_td(alu_td), .alu_psw(alu_psw),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .done(done), .done_idx(done_idx), .psw_q(psw_q), .busy(busy),
        .instr_cnt(instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            s1m[i] = '0; s2m[i] = '0; tdm[i] = '0;
        end
        pswm = '0;
        cntm = 0;
    endtask

    task automatic load(input logic sel, input logic [3:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
        if (sel == LD_SRC2) s2m[a] = d;
        else                s1m[a] = d;
    endtask

    // Issue one instruction and follow it to retirement; optionally write
    // src1[src1_idx] during the ISSUE cycle (must not affect this result)
    task automatic run(input logic [15:0] w, input bit ld_mid, input logic [15:0] ld_val);
        logic [3:0]  t, a, b;
        logic [15:0] op1, op2;
        logic [18:0] r;
        int g, lat;
        t = w[11:8]; a = w[7:4]; b = w[3:0];
        op1 = s1m[a]; op2 = s2m[b];
        r = ref_alu(op1, op2);
        rd_addr = t;
        op_valid = 1'b1; op_code = w;
        g = 0;
        while (!op_ready && g < 8) begin step(); g++; end
        chk("ready_idle", 32'(op_ready), 1);
        step();                                   // handshake edge
        op_valid = 1'b0;
        chk("ready_after_accept", 32'(op_ready), 0);
        chk("busy", 32'(busy), 1);
        chk("opcode_issue", 32'(alu_opcode), 32'(w[15:12]));
        if (ld_mid) begin
            ld_en = 1'b1; ld_sel = LD_SRC1; ld_addr = a; ld_data = ld_val;
        end
        step();                                   // operand fetch edge
        ld_en = 1'b0;
        if (ld_mid) s1m[a] = ld_val;
        chk("src1_exec", 32'(alu_src1), 32'(op1));
        chk("src2_exec", 32'(alu_src2), 32'(op2));
        chk("opcode_exec", 32'(alu_opcode), 32'(w[15:12]));
        chk("src3_exec", 32'(alu_src3), 32'(b));
        lat = 1;
        while (!done && lat < 8) begin step(); lat++; end
        chk("latency", lat, 3);
        chk("rd_same_edge_old", 32'(rd_data), 32'(tdm[t]));
        tdm[t] = r[15:0];
        pswm = r[18:16];
        cntm = (cntm + 1) % (1 << CW);
        chk("done_idx", 32'(done_idx), 32'(t));
        chk("psw", 32'(psw_q), 32'(pswm));
        chk("instr_cnt", 32'(instr_cnt), cntm);
        chk("busy_done", 32'(busy), 0);
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("rd_result", 32'(rd_data), 32'(tdm[t]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int low, gap, seen, guard;
        logic [15:0] w1, w2;
        logic [18:0] r1, r2;

        model_reset();
        step(); step();
        chk("rst_ready", 32'(op_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_src1", 32'(alu_src1), 0);
        chk("rst_opcode", 32'(alu_opcode), 0);
        chk("rst_psw", 32'(psw_q), 0);
        rst_n = 1'b1;
        step();
        chk("rst_rd", 32'(rd_data), 0);

        // Basic add
        load(LD_SRC1, 4'd3, 16'h1234);
        load(LD_SRC2, 4'd5, 16'h0FFF);
        run(16'h2735, 1'b0, '0);
        chk("t1_rd", 32'(rd_data), 'h2233);
        chk("t1_psw", 32'(psw_q), 'b000);
        chk("t1_cnt", 32'(instr_cnt), 1);

        // Carry/zero result, all-zero opcode and src3
        load(LD_SRC1, 4'd0, 16'hFFFF);
        load(LD_SRC2, 4'd0, 16'h0001);
        run(16'h0A00, 1'b0, '0);
        chk("t2_rd", 32'(rd_data), 'h0000);
        chk("t2_psw", 32'(psw_q), 'b110);

        // Load during ISSUE hits the address being fetched: old value used
        load(LD_SRC1, 4'd1, 16'h1000);
        load(LD_SRC2, 4'd1, 16'h0022);
        run(16'h1111, 1'b1, 16'hBEEF);
        chk("t4_old", 32'(rd_data), 'h1022);
        run(16'h2212, 1'b0, '0);
        chk("t4_new", 32'(rd_data), 32'(16'hBEEF + s2m[2]));

        // Reset during EXEC aborts the instruction
        op_valid = 1'b1; op_code = 16'h3C21;
        step();
        op_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_cnt", 32'(instr_cnt), 0);
        step();
        rst_n = 1'b1;
        chk("abort_ready", 32'(op_ready), 1);
        seen = 0;
        rd_addr = 4'hC;
        for (int i = 0; i < 5; i++) begin step(); if (done) seen++; end
        chk("abort_no_done", seen, 0);
        chk("abort_td", 32'(rd_data), 0);
        chk("abort_cnt2", 32'(instr_cnt), 0);
        rd_addr = 4'd7;
        step();
        chk("abort_td7", 32'(rd_data), 0);

        // Back-to-back with op_valid held
        load(LD_SRC1, 4'd1, 16'h0100);
        load(LD_SRC2, 4'd2, 16'h0020);
        load(LD_SRC1, 4'd2, 16'h8000);
        load(LD_SRC2, 4'd1, 16'h8000);
        w1 = 16'h4312; w2 = 16'h5421;
        r1 = ref_alu(s1m[1], s2m[2]);
        r2 = ref_alu(s1m[2], s2m[1]);
        op_valid = 1'b1; op_code = w1;
        step();
        op_code = w2;
        low = 0;
        while (!op_ready && low < 8) begin low++; step(); end
        chk("b2b_low1", low, 3);
        chk("b2b_done1", 32'(done), 1);
        chk("b2b_idx1", 32'(done_idx), 3);
        chk("b2b_psw1", 32'(psw_q), 32'(r1[18:16]));
        step();                                   // second handshake in done cycle
        op_valid = 1'b0;
        gap = 1; low = 0;
        if (!op_ready) low++;
        while (!done && gap < 8) begin step(); gap++; if (!op_ready) low++; end
        chk("b2b_gap", gap, 4);
        chk("b2b_low2", low, 3);
        chk("b2b_idx2", 32'(done_idx), 4);
        chk("b2b_psw2", 32'(psw_q), 32'(r2[18:16]));
        chk("b2b_cnt", 32'(instr_cnt), 2);
        tdm[3] = r1[15:0]; tdm[4] = r2[15:0]; pswm = r2[18:16]; cntm = 2;
        rd_addr = 4'd3; step();
        chk("b2b_rd1", 32'(rd_data), 32'(tdm[3]));
        rd_addr = 4'd4; step();
        chk("b2b_rd2", 32'(rd_data), 32'(tdm[4]));

        // Random loads and instructions
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                load(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
            run(16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        // Counter wrap
        guard = 0;
        while (cntm != (1 << CW) - 1 && guard < 600) begin
            run(16'($urandom), 1'b0, '0);
            guard++;
        end
        chk("cnt_max", 32'(instr_cnt), (1 << CW) - 1);
        run(16'($urandom), 1'b0, '0);
        chk("cnt_wrap", 32'(instr_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
